// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared display/UART constants, serialiser state type and baud divisor helper
package vga_pkg;

   localparam int DEF_CLK_HZ = 101_562_500;
   localparam int DEF_BAUD   = 115_200;

   function automatic int calc_baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   localparam int DEF_BAUD_DIV = calc_baud_div(DEF_CLK_HZ, DEF_BAUD);

   localparam int N_COL       = 160;
   localparam int N_ROW       = 60;
   localparam int COL_WIDTH   = 8;
   localparam int ROW_WIDTH   = 6;
   localparam int CHARS_WIDTH = 7;

   localparam logic [7:0] NEWLINE     = 8'h0A;
   localparam int         FRAME_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - single-byte UART serialiser; even parity bit when TILE_CMD_TX_PARITY_EN is defined
module uart_tx_byte
   import vga_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx,
   output logic       stop_pre,
   output logic       stop_end
);

   localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(BAUD_DIV - 2);

   tx_state_t     state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
`ifdef TILE_CMD_TX_PARITY_EN
   logic          par;
`endif
   logic          tick;

   assign tick     = (baud_cnt == CNT_LAST);
   assign busy     = (state != IDLE);
   assign stop_end = (state == STOP) && tick;
   assign stop_pre = (state == STOP) && (baud_cnt == CNT_PRE);

   // A load on the last stop cycle chains straight into the next start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
`ifdef TILE_CMD_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         if (state == IDLE || tick) baud_cnt <= '0;
         else                       baud_cnt <= baud_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (load) begin
                  state <= START;
                  tx    <= 1'b0;
                  shreg <= data;
`ifdef TILE_CMD_TX_PARITY_EN
                  par   <= ^data;
`endif
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == 3'd7) begin
`ifdef TILE_CMD_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= par;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end
`ifdef TILE_CMD_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (load) begin
                     state <= START;
                     tx    <= 1'b0;
                     shreg <= data;
`ifdef TILE_CMD_TX_PARITY_EN
                     par   <= ^data;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/tile_cmd_tx.sv
// rtl/tile_cmd_tx.sv - tile write command UART frame sender (col,row,char,LF); option TILE_CMD_TX_PARITY_EN
module tile_cmd_tx
   import vga_pkg::*;
#(
   parameter int CLK_HZ        = DEF_CLK_HZ,
   parameter int BAUD          = DEF_BAUD,
   parameter int BAUD_DIV      = calc_baud_div(CLK_HZ, BAUD),
   parameter int N_COL_WIDTH   = COL_WIDTH,
   parameter int N_ROW_WIDTH   = ROW_WIDTH,
   parameter int N_CHARS_WIDTH = CHARS_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [N_COL_WIDTH-1:0]   col_i,
   input  logic [N_ROW_WIDTH-1:0]   row_i,
   input  logic [N_CHARS_WIDTH-1:0] char_i,
   output logic                     tx_o,
   output logic                     done_o
);

   logic [N_ROW_WIDTH-1:0]   row_q;
   logic [N_CHARS_WIDTH-1:0] char_q;
   logic [1:0]               byte_idx;
   logic                     accept;
   logic                     last_byte;
   logic                     ser_load;
   logic [7:0]               ser_data;
   logic                     ser_busy;
   logic                     stop_pre;
   logic                     stop_end;

   // done_o marks the final stop cycle, so a command waiting then is taken
   // on the same edge and the next frame follows with no idle gap.
   assign accept    = valid_i && (ready_o || done_o);
   assign last_byte = (byte_idx == 2'(FRAME_BYTES - 1));
   assign ser_load  = accept || (stop_end && !last_byte);

   // Column goes straight from the port; byte_idx names the byte now on the line.
   always_comb begin
      ser_data = NEWLINE;
      if (accept) begin
         ser_data = 8'(col_i);
      end else begin
         case (byte_idx)
            2'd0:    ser_data = 8'(row_q);
            2'd1:    ser_data = 8'(char_q);
            default: ser_data = NEWLINE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q    <= '0;
         char_q   <= '0;
         byte_idx <= '0;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
      end else begin
         done_o <= ser_busy && stop_pre && last_byte;
         if (accept) begin
            row_q    <= row_i;
            char_q   <= char_i;
            byte_idx <= '0;
            ready_o  <= 1'b0;
         end else if (stop_end) begin
            if (last_byte) ready_o  <= 1'b1;
            else           byte_idx <= byte_idx + 2'd1;
         end
      end
   end

   uart_tx_byte #(
      .BAUD_DIV(BAUD_DIV)
   ) u_tx_byte (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (ser_load),
      .data    (ser_data),
      .busy    (ser_busy),
      .tx      (tx_o),
      .stop_pre(stop_pre),
      .stop_end(stop_end)
   );

endmodule

// File: tb/tb_tile_cmd_tx.sv
// tb/tb_tile_cmd_tx.sv - scoreboard bench for tile_cmd_tx with a UART line decoder model
module tb_tile_cmd_tx;

   localparam int DIV = 8;
`ifdef TILE_CMD_TX_PARITY_EN
   localparam int SYM = 11;
`else
   localparam int SYM = 10;
`endif
   localparam int FRAME = 4 * SYM * DIV;

   typedef struct {
      logic [7:0] b;
      int         c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] col_i;
   logic [5:0] row_i;
   logic [6:0] char_i;
   logic       tx_o;
   logic       done_o;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   free_from = 0;
   exp_t exp_q[$];
   int   exp_done[$];

   tile_cmd_tx #(
      .BAUD_DIV(DIV)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .col_i  (col_i),
      .row_i  (row_i),
      .char_i (char_i),
      .tx_o   (tx_o),
      .done_o (done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: accept happens once valid is seen and the previous frame has
   // ended; byte k starts k symbols later; done sits on the frame's last cycle.
   task automatic cmd(input logic [7:0] c, input logic [5:0] r, input logic [6:0] ch, input bit drop);
      int         a;
      logic [7:0] bs[4];
      col_i   = c;
      row_i   = r;
      char_i  = ch;
      valid_i = 1'b1;
      a = (cyc + 1 > free_from) ? cyc + 1 : free_from;
      bs[0] = c;
      bs[1] = {2'b00, r};
      bs[2] = {1'b0, ch};
      bs[3] = 8'h0A;
      for (int k = 0; k < 4; k++) exp_q.push_back('{b: bs[k], c: a + k * SYM * DIV});
      exp_done.push_back(a + FRAME - 1);
      free_from = a + FRAME;
      while (cyc < a) begin
         @(posedge clk);
         #1;
      end
      if (drop) valid_i = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : uart_mon
      int         st;
      int         bad_len;
      bit         abort;
      logic [SYM-1:0] bits;
      logic [7:0] d;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx_o === 1'b0) begin
            st = cyc;
            bad_len = 0;
            abort = 1'b0;
            bits = '0;
            for (int b = 0; b < SYM && !abort; b++) begin
               for (int k = 0; k < DIV && !abort; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  if (rst) abort = 1'b1;
                  else if (k == 0) bits[b] = tx_o;
                  else if (tx_o !== bits[b]) bad_len++;
               end
            end
            if (!abort) begin
               d = bits[8:1];
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL byte_unexpected: got %02h at cycle %0d, expected no byte", d, st);
               end else begin
                  e = exp_q.pop_front();
                  check("byte_value", d, e.b);
                  check("byte_start_cycle", st, e.c);
                  check("stop_bit", bits[SYM-1], 1);
                  check("bit_width", bad_len, 0);
`ifdef TILE_CMD_TX_PARITY_EN
                  check("parity_bit", bits[9], ^e.b);
`endif
               end
            end
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && done_o === 1'b1) begin
            if (exp_done.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
               check("done_cycle", cyc, exp_done.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      fails++;
      $display("FAIL watchdog: got no end by cycle %0d, expected finish", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int idle_err;
      int a;
      rst = 1'b1;
      valid_i = 1'b0;
      col_i = '0;
      row_i = '0;
      char_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", tx_o, 1);
      check("reset_ready", ready_o, 1);
      check("reset_done", done_o, 0);
      rst = 1'b0;

      idle_err = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || ready_o !== 1'b1 || done_o !== 1'b0) idle_err++;
      end
      check("idle_hold", idle_err, 0);
      @(posedge clk);
      #1;

      cmd(8'd5, 6'd3, 7'h41, 1'b1);

      cmd(8'd200, 6'd63, 7'h7F, 1'b1);
      a = cyc;
      wait_until(a + FRAME / 2);
      valid_i = 1'b1;
      col_i = 8'h11;
      row_i = 6'h22;
      char_i = 7'h33;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      wait_until(free_from + 3);

      cmd(8'd12, 6'd34, 7'h56, 1'b0);
      cmd(8'd159, 6'd59, 7'h20, 1'b1);
      wait_until(free_from + 5);

      cmd(8'd77, 6'd17, 7'h5A, 1'b1);
      a = cyc;
      wait_until(a + 2 * SYM * DIV + 5 * DIV + 2);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_tx", tx_o, 1);
      check("midreset_ready", ready_o, 1);
      check("midreset_done", done_o, 0);
      exp_q.delete();
      exp_done.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      free_from = 0;
      cmd(8'd5, 6'd3, 7'h41, 1'b1);

      cmd(8'h07, 6'd3, 7'h41, 1'b1);

      for (int i = 0; i < 12; i++) begin
         bit drop;
         drop = (i == 11) || ($urandom_range(0, 1) == 1);
         cmd(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 7'($urandom_range(0, 127)), drop);
         if (drop) repeat ($urandom_range(0, 20)) begin
            @(posedge clk);
            #1;
         end
      end

      wait_until(free_from + 5);
      check("bytes_outstanding", exp_q.size(), 0);
      check("done_outstanding", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
